stage_controller: RTL and testbench

STAGE_CONTROLLER -- requirements
Module: stage_controller

---
 rtl/stage_controller.sv | 216 +++++++++++++++++++++
 tb/tb_stage_controller.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage_controller.sv
// stage_controller
//   Multi-cycle instruction sequencer: IDLE -> IF -> ID -> EX -> (MEM) -> (WB) -> IF.
//   Only the state, the sticky illegal flag and the retired-instruction counter
//   are registered; every strobe is decoded combinationally from the current
//   state and the live inputs.
//
// Ports
//   clk           sole clock, rising edge
//   rst           synchronous, active-high reset
//   start         leave IDLE and begin fetching
//   pc_halt       program counter out of bounds (checked in IF)
//   opcode        opcode field of the instruction register, held stable per instruction
//   branch_taken  branch comparator result, valid in EX
//   imem_ready    instruction fetch complete
//   dmem_ready    data access complete
//   imem_req      instruction fetch request
//   dmem_req      data access request
//   dmem_we       data access is a store (only while dmem_req)
//   pc_we         program counter update (one per retired instruction)
//   pc_imm        program counter takes the jump/branch target
//   ir_we         instruction register load
//   rf_we         register file write
//   stage         current state encoding
//   halted        sequencer parked in HALT
//   illegal       HALT was entered on an undecodable opcode
//   instret       retired-instruction count, wraps silently

module stage_controller #(
   parameter int unsigned OPW = 7
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic           pc_halt,
   input  logic [OPW-1:0] opcode,
   input  logic           branch_taken,
   input  logic           imem_ready,
   input  logic           dmem_ready,
   output logic           imem_req,
   output logic           dmem_req,
   output logic           dmem_we,
   output logic           pc_we,
   output logic           pc_imm,
   output logic           ir_we,
   output logic           rf_we,
   output logic [2:0]     stage,
   output logic           halted,
   output logic           illegal,
   output logic [31:0]    instret
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_IF   = 3'd1,
      S_ID   = 3'd2,
      S_EX   = 3'd3,
      S_MEM  = 3'd4,
      S_WB   = 3'd5,
      S_HALT = 3'd6,
      S_BAD  = 3'd7
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_OPIMM  = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   state_t      state_q;
   state_t      state_d;
   logic        illegal_q;
   logic [31:0] instret_q;

   logic [6:0]  op7;
   logic        is_load;
   logic        is_store;
   logic        is_wb_class;
   logic        is_jump;
   logic        is_branch;
   logic        is_ex_retire;
   logic        is_system;

   logic        retire;
   logic        set_illegal;

   assign op7 = opcode[6:0];

   assign is_load      = (op7 == OP_LOAD);
   assign is_store     = (op7 == OP_STORE);
   assign is_jump      = (op7 == OP_JAL) || (op7 == OP_JALR);
   assign is_branch    = (op7 == OP_BRANCH);
   assign is_wb_class  = (op7 == OP_OP) || (op7 == OP_OPIMM) || (op7 == OP_LUI) ||
                         (op7 == OP_AUIPC) || is_jump;
   assign is_ex_retire = is_branch || (op7 == OP_FENCE);
   assign is_system    = (op7 == OP_SYSTEM);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         if (set_illegal) begin
            illegal_q <= 1'b1;
         end
         if (retire) begin
            instret_q <= instret_q + 32'd1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      ir_we       = 1'b0;
      rf_we       = 1'b0;
      retire      = 1'b0;
      set_illegal = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_IF;
            end
         end

         S_IF: begin
            // An out-of-bounds PC wins over any fetch in the same cycle.
            if (pc_halt) begin
               state_d = S_HALT;
            end else begin
               imem_req = 1'b1;
               if (imem_ready) begin
                  ir_we   = 1'b1;
                  state_d = S_ID;
               end
            end
         end

         S_ID: begin
            state_d = S_EX;
         end

         S_EX: begin
            if (is_load || is_store) begin
               state_d = S_MEM;
            end else if (is_wb_class) begin
               state_d = S_WB;
            end else if (is_ex_retire) begin
               retire  = 1'b1;
               state_d = S_IF;
            end else if (is_system) begin
               state_d = S_HALT;
            end else begin
               set_illegal = 1'b1;
               state_d     = S_HALT;
            end
         end

         S_MEM: begin
            dmem_req = 1'b1;
            dmem_we  = is_store;
            if (dmem_ready) begin
               if (is_store) begin
                  retire  = 1'b1;
                  state_d = S_IF;
               end else begin
                  state_d = S_WB;
               end
            end
         end

         S_WB: begin
            rf_we   = 1'b1;
            retire  = 1'b1;
            state_d = S_IF;
         end

         S_HALT: begin
            state_d = S_HALT;
         end

         default: begin
            state_d = S_HALT;
         end
      endcase

      // Strobes are forced quiet during reset so an abandoned request never
      // completes or updates architectural state.
      if (rst) begin
         imem_req = 1'b0;
         dmem_req = 1'b0;
         dmem_we  = 1'b0;
         ir_we    = 1'b0;
         rf_we    = 1'b0;
         retire   = 1'b0;
      end
   end

   assign pc_we   = retire;
   assign pc_imm  = retire && (is_jump || (is_branch && branch_taken));
   assign stage   = state_q;
   assign halted  = (state_q == S_HALT);
   assign illegal = illegal_q;
   assign instret = instret_q;

endmodule

// File: tb/tb_stage_controller.sv
module tb_stage_controller;

   localparam logic [6:0] LOAD   = 7'b0000011;
   localparam logic [6:0] STORE  = 7'b0100011;
   localparam logic [6:0] OP     = 7'b0110011;
   localparam logic [6:0] OPIMM  = 7'b0010011;
   localparam logic [6:0] LUI    = 7'b0110111;
   localparam logic [6:0] AUIPC  = 7'b0010111;
   localparam logic [6:0] JAL    = 7'b1101111;
   localparam logic [6:0] JALR   = 7'b1100111;
   localparam logic [6:0] BRANCH = 7'b1100011;
   localparam logic [6:0] FENCE  = 7'b0001111;
   localparam logic [6:0] SYSTEM = 7'b1110011;

   localparam logic [6:0] OPTAB [15] = '{LOAD, STORE, OP, OPIMM, LUI, AUIPC, JAL, JALR,
                                         BRANCH, FENCE, BRANCH, OP, SYSTEM,
                                         7'b0000000, 7'b1111111};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        pc_halt = 1'b0;
   logic [6:0]  opcode = '0;
   logic        branch_taken = 1'b0;
   logic        imem_ready = 1'b0;
   logic        dmem_ready = 1'b0;
   logic        imem_req, dmem_req, dmem_we, pc_we, pc_imm, ir_we, rf_we;
   logic [2:0]  stage;
   logic        halted, illegal;
   logic [31:0] instret;

   // Strobe vector: {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_imm}
   logic [6:0]  strb;
   assign strb = {imem_req, ir_we, dmem_req, dmem_we, rf_we, pc_we, pc_imm};

   int checks = 0;
   int errors = 0;

   stage_controller #(.OPW(7)) dut (
      .clk(clk), .rst(rst), .start(start), .pc_halt(pc_halt), .opcode(opcode),
      .branch_taken(branch_taken), .imem_ready(imem_ready), .dmem_ready(dmem_ready),
      .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we), .pc_we(pc_we),
      .pc_imm(pc_imm), .ir_we(ir_we), .rf_we(rf_we), .stage(stage), .halted(halted),
      .illegal(illegal), .instret(instret)
   );

   always #5 clk = ~clk;

   // Expected per-cycle behaviour, built from instruction-class rules.
   typedef struct {
      logic [2:0]  stg;
      logic        st, ph, bt, ir, dr;
      logic [6:0]  op;
      logic [6:0]  ex;
      logic [31:0] ie;
      logic        il;
   } cyc_t;

   cyc_t        q[$];
   logic [6:0]  cur_op;
   logic [31:0] cur_ie;
   logic        cur_il;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [2:0] stg, input logic st, input logic ph, input logic bt,
                       input logic ir, input logic dr, input logic [6:0] ex);
      cyc_t c;
      c.stg = stg; c.st = st; c.ph = ph; c.bt = bt; c.ir = ir; c.dr = dr;
      c.op = cur_op; c.ex = ex; c.ie = cur_ie; c.il = cur_il;
      q.push_back(c);
   endtask

   task automatic model_instr(input logic [6:0] op, output logic stop);
      int unsigned wi;
      int unsigned wd;
      logic bt;
      logic s;
      wi = $urandom_range(0, 2);
      wd = $urandom_range(0, 2);
      stop = 1'b0;
      cur_op = op;
      for (int k = 0; k < int'(wi); k++) push(3'd1, rb(), 1'b0, rb(), 1'b0, rb(), 7'b1000000);
      push(3'd1, rb(), 1'b0, rb(), 1'b1, rb(), 7'b1100000);
      push(3'd2, rb(), rb(), rb(), rb(), rb(), 7'b0000000);
      bt = rb();
      case (op)
         LOAD, STORE: begin
            s = (op == STORE);
            push(3'd3, rb(), rb(), bt, rb(), rb(), 7'b0000000);
            for (int k = 0; k < int'(wd); k++)
               push(3'd4, rb(), rb(), rb(), rb(), 1'b0, {2'b00, 1'b1, s, 3'b000});
            push(3'd4, rb(), rb(), rb(), rb(), 1'b1, {2'b00, 1'b1, s, 1'b0, s, 1'b0});
            if (!s) push(3'd5, rb(), rb(), rb(), rb(), rb(), 7'b0000110);
            cur_ie = cur_ie + 32'd1;
         end
         OP, OPIMM, LUI, AUIPC, JAL, JALR: begin
            push(3'd3, rb(), rb(), bt, rb(), rb(), 7'b0000000);
            push(3'd5, rb(), rb(), rb(), rb(), rb(), {6'b000011, (op == JAL) || (op == JALR)});
            cur_ie = cur_ie + 32'd1;
         end
         BRANCH, FENCE: begin
            push(3'd3, rb(), rb(), bt, rb(), rb(), {6'b000001, (op == BRANCH) && bt});
            cur_ie = cur_ie + 32'd1;
         end
         SYSTEM: begin
            push(3'd3, rb(), rb(), bt, rb(), rb(), 7'b0000000);
            stop = 1'b1;
         end
         default: begin
            push(3'd3, rb(), rb(), bt, rb(), rb(), 7'b0000000);
            cur_il = 1'b1;
            stop = 1'b1;
         end
      endcase
   endtask

   task automatic do_reset();
      tick();
      rst = 1'b1; start = 1'b0; pc_halt = 1'b0; imem_ready = 1'b0;
      dmem_ready = 1'b0; branch_taken = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      rst = 1'b1; start = 1'b1; pc_halt = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
      opcode = LOAD;
      #1;
      checks++; if (strb !== 7'b0) begin errors++; $display("FAIL reset_strobes got %b want 0000000", strb); end
      tick();
      checks++; if (stage !== 3'd0) begin errors++; $display("FAIL reset_stage got %0d want 0", stage); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal got %b want 0", illegal); end
      checks++; if (instret !== 32'd0) begin errors++; $display("FAIL reset_instret got %0d want 0", instret); end
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %b want 0", halted); end
      rst = 1'b0; start = 1'b0; pc_halt = 1'b0;
   endtask

   task automatic test_alu();
      logic [2:0] es [5] = '{3'd1, 3'd2, 3'd3, 3'd5, 3'd1};
      logic [6:0] ex [5] = '{7'b1100000, 7'b0, 7'b0, 7'b0000110, 7'b1100000};
      do_reset();
      opcode = OP; imem_ready = 1'b1; dmem_ready = 1'b1;
      go();
      for (int i = 0; i < 5; i++) begin
         #1;
         checks++; if (stage !== es[i]) begin errors++; $display("FAIL alu_stage[%0d] got %0d want %0d", i, stage, es[i]); end
         checks++; if (strb !== ex[i]) begin errors++; $display("FAIL alu_strobes[%0d] got %b want %b", i, strb, ex[i]); end
         tick();
      end
      checks++; if (instret !== 32'd1) begin errors++; $display("FAIL alu_instret got %0d want 1", instret); end
   endtask

   task automatic test_branch();
      logic [2:0] es [4] = '{3'd1, 3'd2, 3'd3, 3'd1};
      logic [6:0] ex [4] = '{7'b1100000, 7'b0, 7'b0000011, 7'b1100000};
      do_reset();
      opcode = BRANCH; branch_taken = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b1;
      go();
      for (int i = 0; i < 4; i++) begin
         #1;
         checks++; if (stage !== es[i]) begin errors++; $display("FAIL br_stage[%0d] got %0d want %0d", i, stage, es[i]); end
         checks++; if (strb !== ex[i]) begin errors++; $display("FAIL br_strobes[%0d] got %b want %b", i, strb, ex[i]); end
         tick();
      end
      checks++; if (instret !== 32'd1) begin errors++; $display("FAIL br_instret got %0d want 1", instret); end
   endtask

   task automatic test_load_stall();
      logic [2:0] es [9] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd5, 3'd1};
      logic       dr [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [6:0] ex [9] = '{7'b1100000, 7'b0, 7'b0, 7'b0010000, 7'b0010000, 7'b0010000,
                             7'b0010000, 7'b0000110, 7'b1100000};
      do_reset();
      opcode = LOAD; imem_ready = 1'b1;
      go();
      for (int i = 0; i < 9; i++) begin
         dmem_ready = dr[i];
         #1;
         checks++; if (stage !== es[i]) begin errors++; $display("FAIL ld_stage[%0d] got %0d want %0d", i, stage, es[i]); end
         checks++; if (strb !== ex[i]) begin errors++; $display("FAIL ld_strobes[%0d] got %b want %b", i, strb, ex[i]); end
         tick();
      end
      checks++; if (instret !== 32'd1) begin errors++; $display("FAIL ld_instret got %0d want 1", instret); end
   endtask

   task automatic test_illegal();
      do_reset();
      opcode = 7'b0000000; imem_ready = 1'b1; dmem_ready = 1'b1;
      go();
      tick(); tick();
      #1;
      checks++; if (strb !== 7'b0) begin errors++; $display("FAIL ill_ex_strobes got %b want 0000000", strb); end
      tick();
      checks++; if (stage !== 3'd6) begin errors++; $display("FAIL ill_stage got %0d want 6", stage); end
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill_flag got %b want 1", illegal); end
      checks++; if (halted !== 1'b1) begin errors++; $display("FAIL ill_halted got %b want 1", halted); end
      checks++; if (instret !== 32'd0) begin errors++; $display("FAIL ill_instret got %0d want 0", instret); end
      start = 1'b1;
      tick();
      start = 1'b0;
      checks++; if (stage !== 3'd6) begin errors++; $display("FAIL ill_start_ignored got %0d want 6", stage); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (stage !== 3'd0) begin errors++; $display("FAIL ill_rst_stage got %0d want 0", stage); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL ill_rst_flag got %b want 0", illegal); end
   endtask

   task automatic test_pc_halt_mem_reset();
      do_reset();
      pc_halt = 1'b1; imem_ready = 1'b1;
      go();
      #1;
      checks++; if (strb !== 7'b0) begin errors++; $display("FAIL pch_strobes got %b want 0000000", strb); end
      tick();
      checks++; if (stage !== 3'd6) begin errors++; $display("FAIL pch_stage got %0d want 6", stage); end
      do_reset();
      opcode = STORE; imem_ready = 1'b1; dmem_ready = 1'b0;
      go();
      tick(); tick(); tick();
      #1;
      checks++; if (strb !== 7'b0011000) begin errors++; $display("FAIL st_mem_strobes got %b want 0011000", strb); end
      rst = 1'b1; dmem_ready = 1'b1;
      #1;
      checks++; if (strb !== 7'b0) begin errors++; $display("FAIL st_rst_strobes got %b want 0000000", strb); end
      tick();
      rst = 1'b0; dmem_ready = 1'b0;
      #1;
      checks++; if (stage !== 3'd0) begin errors++; $display("FAIL st_rst_stage got %0d want 0", stage); end
      checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL st_rst_dmem_req got %b want 0", dmem_req); end
      checks++; if (instret !== 32'd0) begin errors++; $display("FAIL st_rst_instret got %0d want 0", instret); end
   endtask

   task automatic test_instret_wrap();
      do_reset();
      force dut.instret_q = 32'hFFFF_FFFF;
      tick();
      release dut.instret_q;
      #1;
      checks++; if (instret !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload got %h want ffffffff", instret); end
      opcode = BRANCH; branch_taken = 1'b0; imem_ready = 1'b1; dmem_ready = 1'b1;
      go();
      tick(); tick();
      #1;
      checks++; if (strb !== 7'b0000010) begin errors++; $display("FAIL wrap_ex_strobes got %b want 0000010", strb); end
      tick();
      checks++; if (instret !== 32'h0000_0000) begin errors++; $display("FAIL wrap_instret got %h want 00000000", instret); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL wrap_illegal got %b want 0", illegal); end
   endtask

   task automatic test_random();
      logic stop;
      cyc_t c;
      for (int run = 0; run < 10; run++) begin
         q.delete();
         cur_ie = '0; cur_il = 1'b0; cur_op = 7'($urandom);
         for (int k = 0; k < int'($urandom_range(0, 2)); k++)
            push(3'd0, 1'b0, rb(), rb(), rb(), rb(), 7'b0);
         push(3'd0, 1'b1, rb(), rb(), rb(), rb(), 7'b0);
         stop = 1'b0;
         for (int i = 0; i < 6 && !stop; i++) begin
            int unsigned sel;
            sel = $urandom_range(0, 15);
            if (sel == 15) begin
               push(3'd1, rb(), 1'b1, rb(), rb(), rb(), 7'b0);
               stop = 1'b1;
            end else begin
               model_instr(OPTAB[sel], stop);
            end
         end
         if (!stop) push(3'd1, rb(), 1'b1, rb(), rb(), rb(), 7'b0);
         for (int k = 0; k < 2; k++) push(3'd6, 1'b1, rb(), rb(), rb(), rb(), 7'b0);

         do_reset();
         for (int n = 0; n < q.size(); n++) begin
            c = q[n];
            start = c.st; pc_halt = c.ph; branch_taken = c.bt;
            imem_ready = c.ir; dmem_ready = c.dr; opcode = c.op;
            #1;
            checks++; if (stage !== c.stg) begin errors++; $display("FAIL rnd_stage r%0d c%0d got %0d want %0d", run, n, stage, c.stg); end
            checks++; if (strb !== c.ex) begin errors++; $display("FAIL rnd_strobes r%0d c%0d got %b want %b", run, n, strb, c.ex); end
            checks++; if (instret !== c.ie) begin errors++; $display("FAIL rnd_instret r%0d c%0d got %0d want %0d", run, n, instret, c.ie); end
            checks++; if (illegal !== c.il) begin errors++; $display("FAIL rnd_illegal r%0d c%0d got %b want %b", run, n, illegal, c.il); end
            checks++; if (halted !== (c.stg == 3'd6)) begin errors++; $display("FAIL rnd_halted r%0d c%0d got %b want %b", run, n, halted, c.stg == 3'd6); end
            tick();
         end
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_branch();
      test_load_stall();
      test_illegal();
      test_pc_halt_mem_reset();
      test_instret_wrap();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
